// File: rtl/robot_pkg.sv
// Shared types for the robot navigation controller.
// Motor command encoding and motion FSM states.
package robot_pkg;

  typedef enum logic [1:0] {
    CMD_STOP = 2'd0,
    CMD_FWD  = 2'd1,
    CMD_SLOW = 2'd2,
    CMD_TURN = 2'd3
  } motor_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_SLOW  = 3'd2,
    S_STOP  = 3'd3,
    S_TURN  = 3'd4,
    S_FAULT = 3'd5
  } nav_state_t;

  function automatic motor_cmd_t cmd_of(nav_state_t s);
    unique case (s)
      S_FWD:   cmd_of = CMD_FWD;
      S_SLOW:  cmd_of = CMD_SLOW;
      S_TURN:  cmd_of = CMD_TURN;
      default: cmd_of = CMD_STOP;
    endcase
  endfunction

endpackage

// File: rtl/robot_nav_ctrl_if.sv
// Distance-sensor read handshake (req/valid) with data word.
// master = controller side, slave = sensor front end.
interface robot_nav_ctrl_if #(
  parameter int DIST_W = 16
);
  logic              sens_req;
  logic              sens_valid;
  logic [DIST_W-1:0] dist_v;

  modport master (
    output sens_req,
    input  sens_valid,
    input  dist_v
  );

  modport slave (
    input  sens_req,
    output sens_valid,
    output dist_v
  );
endinterface

// File: rtl/robot_sample_sched.sv
// Periodic sensor-read scheduler: period counter,
// request/handshake tracking and request timeout.
module robot_sample_sched #(
  parameter int DIST_W        = 16,
  parameter int SAMPLE_PERIOD = 8,
  parameter int TIMEOUT       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              halt,
  robot_nav_ctrl_if.master  sens,
  output logic              sample_stb,
  output logic [DIST_W-1:0] sample_d,
  output logic              timeout
);
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [PW-1:0] period_cnt;
  logic [WW-1:0] wait_cnt;
  logic          req;
  logic          active;
  logic          xfer;

  assign active     = en && !halt;
  assign xfer       = req && sens.sens_valid;
  // Timeout fires on the last allowed cycle even if valid arrives then.
  assign timeout    = active && req &&
                      (wait_cnt == WW'(TIMEOUT - 1));
  assign sample_stb = active && xfer && !timeout;
  assign sample_d   = sens.dist_v;
  assign sens.sens_req = req;

  // Request generation, wait counting and cancellation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req        <= 1'b0;
      period_cnt <= '0;
      wait_cnt   <= '0;
    end else if (!active || timeout) begin
      req        <= 1'b0;
      period_cnt <= '0;
      wait_cnt   <= '0;
    end else if (xfer) begin
      req        <= 1'b0;
      period_cnt <= '0;
      wait_cnt   <= '0;
    end else if (req) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else if (period_cnt == PW'(SAMPLE_PERIOD - 1)) begin
      req        <= 1'b1;
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/robot_nav_ctrl.sv
// Robot navigation controller: distance classifier with
// hysteresis and the cruise/slow/stop/turn motion FSM.
module robot_nav_ctrl
  import robot_pkg::*;
#(
  parameter int DIST_W        = 16,
  parameter int STOP_TH       = 80,
  parameter int SLOW_TH       = 200,
  parameter int HYST          = 16,
  parameter int TURN_CYCLES   = 32,
  parameter int SAMPLE_PERIOD = 8,
  parameter int TIMEOUT       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  robot_nav_ctrl_if.master sens,
  output logic [1:0]       motor_cmd,
  output logic             turn_dir,
  output logic             fault,
  output logic [2:0]       state_o
);
  localparam int TW = $clog2(TURN_CYCLES + 1);

  nav_state_t        state, state_n;
  logic [TW-1:0]     turn_cnt, turn_cnt_n;
  logic              dir_n, fault_n;
  logic              sample_stb, timeout;
  logic [DIST_W-1:0] sample_d;
  logic              near, mid, far;
  logic [DIST_W:0]   far_th;

  robot_sample_sched #(
    .DIST_W       (DIST_W),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .TIMEOUT      (TIMEOUT)
  ) u_sched (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .halt      (fault),
    .sens      (sens),
    .sample_stb(sample_stb),
    .sample_d  (sample_d),
    .timeout   (timeout)
  );

  // Far threshold widened one bit so SLOW_TH+HYST cannot wrap.
  assign far_th = (DIST_W + 1)'(SLOW_TH + HYST);
  assign near   = sample_d < DIST_W'(STOP_TH);
  assign mid    = !near && (sample_d < DIST_W'(SLOW_TH));
  assign far    = {1'b0, sample_d} >= far_th;

  // Next-state, turn timer and direction logic.
  always_comb begin
    state_n    = state;
    turn_cnt_n = turn_cnt;
    dir_n      = turn_dir;
    fault_n    = fault;
    if (state == S_FAULT) begin
      state_n = S_FAULT;
    end else if (timeout) begin
      state_n    = S_FAULT;
      fault_n    = 1'b1;
      turn_cnt_n = '0;
    end else if (!en) begin
      state_n    = S_IDLE;
      turn_cnt_n = '0;
    end else begin
      unique case (state)
        S_IDLE: if (sample_stb) begin
          unique case (1'b1)
            near:    state_n = S_STOP;
            far:     state_n = S_FWD;
            default: state_n = S_SLOW;
          endcase
        end
        S_FWD: if (sample_stb) begin
          unique case (1'b1)
            near:    state_n = S_STOP;
            mid:     state_n = S_SLOW;
            default: state_n = S_FWD;
          endcase
        end
        S_SLOW: if (sample_stb) begin
          unique case (1'b1)
            near:    state_n = S_STOP;
            far:     state_n = S_FWD;
            default: state_n = S_SLOW;
          endcase
        end
        S_STOP: begin
          state_n    = S_TURN;
          turn_cnt_n = TW'(TURN_CYCLES - 1);
          dir_n      = !turn_dir;
        end
        S_TURN: begin
          if (turn_cnt == '0) state_n = S_SLOW;
          else turn_cnt_n = turn_cnt - 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Registered state and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      turn_cnt  <= '0;
      turn_dir  <= 1'b0;
      fault     <= 1'b0;
      motor_cmd <= CMD_STOP;
    end else begin
      state     <= state_n;
      turn_cnt  <= turn_cnt_n;
      turn_dir  <= dir_n;
      fault     <= fault_n;
      motor_cmd <= cmd_of(state_n);
    end
  end

  assign state_o = state;
endmodule

// File: tb/tb_robot_nav_ctrl.sv
// Directed self-checking bench for robot_nav_ctrl.
// Default parameters; outputs sampled 1ns after rising edge.
module tb_robot_nav_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] motor_cmd;
  logic       turn_dir;
  logic       fault;
  logic [2:0] state_o;
  int         checks = 0;
  int         failures = 0;
  int         n;

  robot_nav_ctrl_if #(.DIST_W(16)) sens ();

  robot_nav_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sens     (sens),
    .motor_cmd(motor_cmd),
    .turn_dir (turn_dir),
    .fault    (fault),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output int cnt);
    cnt = 0;
    while (!sens.sens_req && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic send(input logic [15:0] d);
    sens.sens_valid = 1'b1;
    sens.dist_v     = d;
    tick();
    sens.sens_valid = 1'b0;
  endtask

  task automatic run_turn(output int cnt);
    cnt = 0;
    while (state_o == 3'd4 && cnt < 100) begin
      sens.sens_valid = sens.sens_req;
      sens.dist_v     = 16'd50;
      tick();
      cnt++;
    end
    sens.sens_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    sens.sens_valid = 1'b0;
    sens.dist_v     = '0;
    tick();
    tick();
    chk("rst_req", int'(sens.sens_req), 0);
    chk("rst_cmd", int'(motor_cmd), 0);
    chk("rst_dir", int'(turn_dir), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_state", int'(state_o), 0);
    rst = 1'b0;
    tick();
    chk("idle_no_req", int'(sens.sens_req), 0);

    en = 1'b1;
    wait_req(n);
    chk("first_req_lat", n, 8);
    send(16'd300);
    chk("far_cmd", int'(motor_cmd), 1);
    chk("far_req_low", int'(sens.sens_req), 0);

    wait_req(n);
    chk("next_req_lat", n, 8);
    send(16'd150);
    chk("mid_slow", int'(motor_cmd), 2);
    wait_req(n);
    send(16'd210);
    chk("band_stay_slow", int'(motor_cmd), 2);
    wait_req(n);
    send(16'd216);
    chk("hyst_fwd", int'(motor_cmd), 1);

    wait_req(n);
    send(16'd50);
    chk("obst_stop", int'(motor_cmd), 0);
    chk("obst_state", int'(state_o), 3);
    tick();
    chk("turn_cmd", int'(motor_cmd), 3);
    chk("turn_dir1", int'(turn_dir), 1);
    run_turn(n);
    chk("turn_len1", n, 32);
    chk("after_turn", int'(motor_cmd), 2);

    wait_req(n);
    send(16'd40);
    chk("obst2_stop", int'(state_o), 3);
    tick();
    chk("turn_dir0", int'(turn_dir), 0);
    run_turn(n);
    chk("turn_len2", n, 32);
    chk("after_turn2", int'(state_o), 2);

    wait_req(n);
    chk("req_before_drop", int'(sens.sens_req), 1);
    en = 1'b0;
    tick();
    chk("drop_req", int'(sens.sens_req), 0);
    chk("drop_idle", int'(state_o), 0);
    chk("drop_cmd", int'(motor_cmd), 0);
    en = 1'b1;
    wait_req(n);
    chk("reen_lat", n, 8);
    send(16'hFFFF);
    chk("max_fwd", int'(state_o), 1);

    wait_req(n);
    n = 0;
    while (!fault && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_lat", n, 16);
    chk("to_cmd", int'(motor_cmd), 0);
    chk("to_state", int'(state_o), 5);
    chk("to_req", int'(sens.sens_req), 0);
    sens.dist_v     = 16'd300;
    sens.sens_valid = 1'b1;
    tick();
    tick();
    sens.sens_valid = 1'b0;
    chk("late_valid", int'(state_o), 5);
    chk("late_fault", int'(fault), 1);
    en = 1'b0;
    tick();
    chk("fault_en0", int'(state_o), 5);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("clr_fault", int'(fault), 0);
    chk("clr_state", int'(state_o), 0);

    en = 1'b1;
    wait_req(n);
    for (int i = 0; i < 15; i++) tick();
    chk("pre_to_state", int'(state_o), 0);
    send(16'd300);
    chk("prio_fault", int'(fault), 1);
    chk("prio_state", int'(state_o), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/robot_nav_ctrl.md
# robot_nav_ctrl

Navigation controller for the `robot` block. It schedules periodic distance-sensor reads over a req/valid handshake and classifies each sample against stop and slow thresholds with hysteresis. From that it sequences the motor command through cruise, slow, stop and timed-turn states, and latches a sticky fault on sensor timeout. It sits between the distance-sensor front end (the source of `dist_v`) and the motor driver.

## Interface

- `DIST_W`, 16: distance word width
- `STOP_TH`, 80: distance below this is "near"
- `SLOW_TH`, 200: distance below this, and at or above `STOP_TH`, is "mid"
- `HYST`, 16: return to cruise requires `d >= SLOW_TH + HYST`
- `TURN_CYCLES`, 32: duration of a turn, in cycles
- `SAMPLE_PERIOD`, 8: cycles from handshake completion (or enable) to the next request; must be >= 2
- `TIMEOUT`, 16: cycles `sens_req` may stay high without `sens_valid` before fault

Ports (one clock; reset is asynchronous and active-high):

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  enables sampling and motion
- `sens_req`  out  1  sensor read request
- `sens_valid`  in  1  sensor data valid
- `dist_v`  in  DIST_W  distance sample, valid while `sens_valid` is high
- `motor_cmd`  out  2  0 = STOP, 1 = FWD, 2 = SLOW, 3 = TURN
- `turn_dir`  out  1  0 = left, 1 = right; toggles on each TURN entry
- `fault`  out  1  sticky sensor-timeout flag
- `state_o`  out  3  current FSM state, for debug and formal

## Operation

- **Reset values:** `sens_req` = 0, `motor_cmd` = STOP, `turn_dir` = 0, `fault` = 0, state = IDLE, all counters = 0.
- **Handshake:** a transfer occurs in a cycle where `sens_req` and `sens_valid` are both high.
  - `sens_valid` while `sens_req` is low is ignored.
  - `sens_req` is held high until the transfer, then deasserts on the next edge.
- **Period counter:**
  - Counts only while `en = 1`, `fault = 0` and no request is outstanding.
  - When it reaches `SAMPLE_PERIOD-1`, `sens_req` rises on the next edge and the counter clears.
  - The counter also clears on transfer.
- **Timeout:**
  - The wait counter increments each cycle `sens_req` is high without `sens_valid`.
  - On reaching `TIMEOUT`: `fault` = 1, `sens_req` = 0, state = FAULT, `motor_cmd` = STOP.
  - FAULT is exited only by `rst`.
- **Classification of `dist_v` on transfer:**
  - near: `d < STOP_TH`
  - mid: `STOP_TH <= d < SLOW_TH`
  - far: `d >= SLOW_TH + HYST`, computed at DIST_W+1 bits with no overflow
  - band: the remaining range
- **FSM states:** IDLE, FWD, SLOW, STOP, TURN, FAULT.
- **IDLE** (`motor_cmd` STOP), on transfer:
  - near → STOP
  - mid or band → SLOW
  - far → FWD
- **FWD**, on transfer:
  - near → STOP
  - mid → SLOW
  - band or far → stay in FWD
- **SLOW**, on transfer:
  - near → STOP
  - far → FWD
  - otherwise stay in SLOW
- **STOP:** lasts exactly one cycle, then → TURN. On the transition, load the turn counter with `TURN_CYCLES-1` and toggle `turn_dir`.
- **TURN:**
  - Decrements the turn counter each cycle; at 0 → SLOW.
  - Transfers during TURN complete normally but do not change state.
- **Enable low:** `en = 0` in any state except FAULT → IDLE on the next edge. `sens_req` drops, the outstanding request is cancelled, and the period, wait and turn counters clear.
- **Simultaneous events:**
  - Timeout has priority over a transfer in the same cycle.
  - `en = 0` has priority over a transfer.

## Timing

- Transfer at edge t: `motor_cmd` and state reflect the new class at t+1, and `sens_req` is low at t+1.
- First request appears `SAMPLE_PERIOD` cycles after `en` is first sampled high.
- Next request appears `SAMPLE_PERIOD` cycles after the transfer.
- STOP is visible for 1 cycle; TURN is visible for `TURN_CYCLES` cycles.
- All outputs are registered; there is no combinational input-to-output path.

## Structure

- **Package `robot_pkg`:** `motor_cmd_t` enum (STOP/FWD/SLOW/TURN) and `nav_state_t` enum (the 6 states).
- **Sub-module `robot_sample_sched`:** period counter, request/handshake logic and timeout.
  - Outputs: `sample_stb`, `sample_d`, `timeout`.
  - The top level holds the classifier and the motion FSM.

## Test plan

Default parameters throughout.

- **Reset and first sample:** `rst` high, then `en` = 1 → `sens_req` rises 8 cycles later. `sens_valid` with `dist_v` = 300 → `motor_cmd` = FWD next cycle.
- **Hysteresis:** in FWD, samples 150 then 210 → SLOW, stays SLOW. Next sample 216 → FWD.
- **Obstacle:** in FWD, sample 50 → STOP for 1 cycle, TURN for 32 cycles with `turn_dir` = 1, then SLOW. A second obstacle gives `turn_dir` = 0.
- **Timeout:** hold `sens_valid` = 0 after `sens_req` → `fault` = 1 and `motor_cmd` = STOP 16 cycles later. A late `sens_valid` is ignored; only `rst` clears the fault.
- **Enable drop:** `en` = 0 while `sens_req` is high → `sens_req` = 0, IDLE next cycle. Re-enable → request 8 cycles later.
- **Priority:** timeout and `sens_valid` in the same cycle → FAULT. `dist_v` = 65535 in IDLE → FWD, no overflow.
